// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity encodings and the parity helper
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int MAX_DATA_W = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity bit that makes the frame satisfy par_type; zero-extended data is harmless
    function automatic logic parity(input logic [MAX_DATA_W-1:0] data, input logic par_type);
        return (^data) ^ par_type;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end for the UART receiver: 2-flop synchronizer, falling-edge detect,
// per-bit oversampling counter and 2-of-3 majority vote around the bit centre.
module uart_rx_sampler #(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    input  logic active,
    input  logic start,
    output logic rx_fall,
    output logic bit_val,
    output logic bit_done,
    output logic bit_end
);

    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] SAMP0    = CNT_W'(PRESCALE / 2 - 1);
    localparam logic [CNT_W-1:0] SAMP1    = CNT_W'(PRESCALE / 2);
    localparam logic [CNT_W-1:0] SAMP2    = CNT_W'(PRESCALE / 2 + 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             prev_r;
    logic             samp0_r;
    logic             samp1_r;
    logic [CNT_W-1:0] edge_cnt_r;
    logic [CNT_W-1:0] edge_cnt_s;

    // Synchronizer plus one-cycle history of the synchronized line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rx_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // The detect cycle counts as edge 0 of the start bit, so the counter enters START at 1
    always_comb begin
        edge_cnt_s = CNT_W'(0);
        if (start) begin
            edge_cnt_s = CNT_W'(1);
        end else if (active) begin
            if (edge_cnt_r == CNT_LAST) begin
                edge_cnt_s = CNT_W'(0);
            end else begin
                edge_cnt_s = edge_cnt_r + CNT_W'(1);
            end
        end else begin
            edge_cnt_s = CNT_W'(0);
        end
    end

    // Bit-time counter and the two early samples of the majority vote
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_r <= CNT_W'(0);
            samp0_r    <= 1'b1;
            samp1_r    <= 1'b1;
        end else begin
            edge_cnt_r <= edge_cnt_s;
            if (active && (edge_cnt_r == SAMP0)) begin
                samp0_r <= sync2_r;
            end
            if (active && (edge_cnt_r == SAMP1)) begin
                samp1_r <= sync2_r;
            end
        end
    end

    assign rx_fall  = !sync2_r && prev_r;
    assign bit_val  = (samp0_r & samp1_r) | (samp0_r & sync2_r) | (samp1_r & sync2_r);
    assign bit_done = active && (edge_cnt_r == SAMP2);
    assign bit_end  = active && (edge_cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, data shift register and parity/stop checks on top of the
// oversampling front end; results leave on registered one-cycle strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_EN     = 1,
    parameter int PAR_TYPE   = 1,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  busy_flag
);

    localparam int   BIT_CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic PAR_TYPE_BIT = (PAR_TYPE != 0) ? PAR_ODD : PAR_EVEN;

    uart_state_e           state_r;
    uart_state_e           state_s;
    logic [BIT_CNT_W-1:0]  bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  par_err_r;

    logic rx_fall_s;
    logic bit_val_s;
    logic bit_done_s;
    logic bit_end_s;
    logic active_s;
    logic start_s;
    logic last_bit_s;
    logic shift_we_s;
    logic par_chk_s;
    logic frame_chk_s;
    logic valid_s;
    logic perr_s;
    logic ferr_s;

    assign active_s   = (state_r != ST_IDLE);
    assign start_s    = (state_r == ST_IDLE) && rx_fall_s;
    assign last_bit_s = (bit_cnt_r == BIT_CNT_W'(DATA_WIDTH - 1));

    uart_rx_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .active   (active_s),
        .start    (start_s),
        .rx_fall  (rx_fall_s),
        .bit_val  (bit_val_s),
        .bit_done (bit_done_s),
        .bit_end  (bit_end_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: STOP leaves at the vote so a back-to-back start edge is not missed
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_fall_s) state_s = ST_START;
                else           state_s = ST_IDLE;
            end
            ST_START: begin
                if (bit_done_s && bit_val_s) state_s = ST_IDLE;
                else if (bit_end_s)          state_s = ST_DATA;
                else                         state_s = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && last_bit_s) state_s = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
                else                         state_s = ST_DATA;
            end
            ST_PARITY: begin
                if (bit_end_s) state_s = ST_STOP;
                else           state_s = ST_PARITY;
            end
            ST_STOP: begin
                if (bit_done_s) state_s = ST_IDLE;
                else            state_s = ST_STOP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Per-state strobes; a parity failure masks a simultaneous bad stop bit
    always_comb begin
        shift_we_s  = 1'b0;
        par_chk_s   = 1'b0;
        frame_chk_s = 1'b0;
        case (state_r)
            ST_DATA:   shift_we_s  = bit_done_s;
            ST_PARITY: par_chk_s   = bit_done_s;
            ST_STOP:   frame_chk_s = bit_done_s;
            default:   shift_we_s  = 1'b0;
        endcase
        valid_s = frame_chk_s && !par_err_r && bit_val_s;
        perr_s  = frame_chk_s && par_err_r;
        ferr_s  = frame_chk_s && !par_err_r && !bit_val_s;
    end

    // Datapath: bit index, shift register and the latched parity verdict
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r <= BIT_CNT_W'(0);
            shift_r   <= DATA_WIDTH'(0);
            par_err_r <= 1'b0;
        end else begin
            if (start_s) begin
                bit_cnt_r <= BIT_CNT_W'(0);
                par_err_r <= 1'b0;
            end else begin
                if ((state_r == ST_DATA) && bit_end_s) begin
                    bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                end
                if (par_chk_s) begin
                    par_err_r <= (bit_val_s != parity(MAX_DATA_W'(shift_r), PAR_TYPE_BIT));
                end
            end
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (shift_we_s && (bit_cnt_r == BIT_CNT_W'(i))) begin
                    shift_r[i] <= bit_val_s;
                end
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            P_DATA        <= DATA_WIDTH'(0);
            DATA_VALID    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            busy_flag     <= 1'b0;
        end else begin
            if (valid_s) begin
                P_DATA <= shift_r;
            end
            DATA_VALID    <= valid_s;
            parity_error  <= perr_s;
            framing_error <= ferr_s;
            busy_flag     <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames, with every
// output pulse compared against a frame-level reference model (time, kind and P_DATA).
module tb_uart_rx;

    localparam int P     = 8;
    localparam int DW    = 8;
    localparam int PE    = 1;
    localparam int PT    = 1;
    localparam int NBITS = 1 + DW + PE + 1;
    // Clocks from the first edge sampling the start bit to DATA_VALID high
    localparam int LAT   = 2 + P * (1 + DW + PE) + P / 2 + 2;

    localparam int K_VALID = 0;
    localparam int K_PERR  = 1;
    localparam int K_FERR  = 2;

    typedef struct {
        int         t;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_in = 1'b1;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          parity_error;
    logic          framing_error;
    logic          busy_flag;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    ev_t        exp_q[$];
    ev_t        obs_q[$];
    logic [7:0] model_pdata = 8'h00;

    uart_rx #(
        .DATA_WIDTH (DW),
        .PAR_EN     (PE),
        .PAR_TYPE   (PT),
        .PRESCALE   (P)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_in         (rx_in),
        .P_DATA        (P_DATA),
        .DATA_VALID    (DATA_VALID),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .busy_flag     (busy_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every asserted strobe; two at once or a two-cycle pulse shows up as extra events
    always @(negedge clk) begin
        if (rst) begin
            if (DATA_VALID)    obs_q.push_back('{cyc, K_VALID, P_DATA});
            if (parity_error)  obs_q.push_back('{cyc, K_PERR, P_DATA});
            if (framing_error) obs_q.push_back('{cyc, K_FERR, P_DATA});
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame from a negedge and predict its outcome from the frame contents
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
        int   t0;
        int   kind;
        logic good_par;
        t0       = cyc;
        good_par = 1'(($countones(d) + PT) % 2);
        if (PE != 0 && pbit != good_par) kind = K_PERR;
        else if (!sbit)                  kind = K_FERR;
        else                             kind = K_VALID;
        if (kind == K_VALID) model_pdata = d;
        exp_q.push_back('{t0 + LAT, kind, model_pdata});
        rx_in = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rx_in = d[i];
            repeat (P) @(negedge clk);
        end
        if (PE != 0) begin
            rx_in = pbit;
            repeat (P) @(negedge clk);
        end
        rx_in = sbit;
        repeat (P) @(negedge clk);
    endtask

    task automatic compare_events(input string tag);
        int n;
        idle(2 * P);
        check_value({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_value($sformatf("%s_%0d_time", tag, i), obs_q[i].t, exp_q[i].t);
            check_value($sformatf("%s_%0d_kind", tag, i), obs_q[i].kind, exp_q[i].kind);
            check_value($sformatf("%s_%0d_data", tag, i), obs_q[i].data, exp_q[i].data);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int         c0;
        logic [7:0] d;
        int         mode;
        logic       pbit;
        logic       sbit;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_pdata", P_DATA, 8'h00);
        check_value("rst_valid", DATA_VALID, 1'b0);
        check_value("rst_perr", parity_error, 1'b0);
        check_value("rst_ferr", framing_error, 1'b0);
        check_value("rst_busy", busy_flag, 1'b0);
        rst = 1'b1;
        idle(4);

        send_frame(8'hF9, 1'b1, 1'b1);
        compare_events("good");
        check_value("good_pdata", P_DATA, 8'hF9);

        // Abort a frame partway through data bit 3
        d = 8'hF9;
        rx_in = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_in = d[i];
            repeat (P) @(negedge clk);
        end
        rx_in = d[3];
        repeat (P / 2) @(negedge clk);
        check_value("mid_busy", busy_flag, 1'b1);
        rst = 1'b0;
        #1;
        check_value("arst_pdata", P_DATA, 8'h00);
        check_value("arst_valid", DATA_VALID, 1'b0);
        check_value("arst_perr", parity_error, 1'b0);
        check_value("arst_ferr", framing_error, 1'b0);
        check_value("arst_busy", busy_flag, 1'b0);
        model_pdata = 8'h00;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2 * NBITS * P);
        compare_events("abort");
        send_frame(8'hF9, 1'b1, 1'b1);
        compare_events("post_rst");

        send_frame(8'h85, 1'b1, 1'b1);
        compare_events("par_err");
        check_value("par_err_pdata", P_DATA, 8'hF9);

        send_frame(8'h40, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (3 * P) @(negedge clk);
        idle(P);
        send_frame(8'hF2, 1'b0, 1'b1);
        compare_events("frm_err");
        check_value("frm_err_pdata", P_DATA, 8'hF2);

        // Two-clock low glitch must be rejected by the start-bit vote
        c0 = cyc;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        check_value("glitch_busy_hi", busy_flag, 1'b1);
        repeat (P) @(negedge clk);
        check_value("glitch_busy_lo", busy_flag, 1'b0);
        check_value("glitch_elapsed", cyc - c0, 4 + P);
        compare_events("glitch");
        check_value("glitch_pdata", P_DATA, 8'hF2);

        send_frame(8'hF9, 1'b1, 1'b1);
        send_frame(8'h85, 1'b0, 1'b1);
        idle(2 * P);
        check_value("b2b_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check_value("b2b_gap", obs_q[1].t - obs_q[0].t, NBITS * P);
        end
        compare_events("b2b");
        check_value("b2b_pdata", P_DATA, 8'h85);

        // Random frames: good, bad parity, bad stop, or both, with random idle gaps
        for (int n = 0; n < 30; n++) begin
            d    = 8'($urandom);
            mode = int'($urandom_range(0, 3));
            pbit = 1'(($countones(d) + PT) % 2);
            if (mode == 1 || mode == 3) pbit = ~pbit;
            sbit = (mode >= 2) ? 1'b0 : 1'b1;
            send_frame(d, pbit, sbit);
            if (!sbit) idle(int'($urandom_range(1, 2 * P)));
            else       idle(int'($urandom_range(0, 2 * P)));
        end
        compare_events("rand");
        check_value("rand_pdata", P_DATA, model_pdata);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver for the UART link. It consumes the frame that the TX stage drives on tx_out and rebuilds the parallel word. It oversamples the line at PRESCALE clocks per bit, checks the start, parity and stop bits, and then presents the word with a one-cycle valid strobe. Frame format matches TX: start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).

Parameters:
DATA_WIDTH, 8, payload bits per frame
PAR_EN, 1, 1 = parity bit present, 0 = no parity bit
PAR_TYPE, 1, 0 = even parity, 1 = odd parity (same encoding as TX)
PRESCALE, 8, clocks per bit; even, legal range 4..32

Ports:
clk  input  1  system clock, PRESCALE x bit rate
rst  input  1  asynchronous active-low reset
rx_in  input  1  serial line, idles high, asynchronous to clk
P_DATA  output  DATA_WIDTH  last correctly received word
DATA_VALID  output  1  one-cycle pulse when P_DATA is updated
parity_error  output  1  one-cycle pulse on parity mismatch
framing_error  output  1  one-cycle pulse on bad stop bit
busy_flag  output  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Reset (rst=0, async): state=IDLE, counters=0, sync flops=1, P_DATA=0, DATA_VALID=0, parity_error=0, framing_error=0, busy_flag=0.
- A reset asserted mid-frame abandons the frame. No pulse is issued.
- rx_in passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value rx_s.
- Bit timing:
  - edge_cnt runs 0..PRESCALE-1 in every non-IDLE state.
  - Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the 2-of-3 majority, registered at edge_cnt = P/2+1.
  - At edge_cnt = PRESCALE-1: edge_cnt wraps to 0 and the FSM advances.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s=0 -> START, edge_cnt=0.
  - START: voted bit=1 -> glitch, return to IDLE at the vote cycle. Voted bit=0 -> DATA at wrap.
  - DATA: bit_cnt 0..DATA_WIDTH-1. The voted bit is written into shift register position bit_cnt (LSB first). After the last bit: PARITY if PAR_EN=1, else STOP.
  - PARITY: expected = XOR(data) XOR PAR_TYPE. A mismatch sets an internal par_err flag. Go to STOP at wrap.
  - STOP: the voted bit is checked at edge_cnt = P/2+1. In the next cycle exactly one of these outcomes occurs:
    - par_err=1: parity_error=1. P_DATA holds; DATA_VALID=0.
    - par_err=0 and stop=0: framing_error=1. P_DATA holds; DATA_VALID=0.
    - par_err=0 and stop=1: P_DATA <= shift register; DATA_VALID=1.
    - par_err=1 and stop=0 together: report parity_error only.
  - The FSM returns to IDLE in the same cycle as the STOP vote, so back-to-back frames resynchronize on the next falling edge inside the stop bit's second half.
- Latency: DATA_VALID rises (2 sync + PRESCALE*(1+DATA_WIDTH+PAR_EN) + P/2+2) clocks after the rx_in falling edge.
- busy_flag is high from the IDLE->START transition until the return to IDLE.
- The error pulses and DATA_VALID are mutually exclusive and are never high for more than one cycle.
- After a framing error, a line held low stays in IDLE until it returns high and then falls again. IDLE watches for a falling edge (rx_s=0 with previous rx_s=1), not a low level.

Decomposition:
- Package uart_pkg:
  - FSM state enum (shared encoding with TX)
  - PAR_EVEN/PAR_ODD constants
  - function parity(data, type) reused by TX
- One sub-module, uart_rx_sampler: synchronizer, edge_cnt, 3-sample majority vote. Outputs bit_val, bit_done (vote strobe) and bit_end (wrap strobe). The FSM, shift register and checks stay in uart_rx.

Test Plan:
- Reset: rst=0 during a DATA bit -> all outputs 0 asynchronously, no pulse after release; next frame 0xF9 still received.
- Good frame: 0xF9, parity bit 1 (odd, six ones), stop 1, PRESCALE=8 -> P_DATA=0xF9, DATA_VALID high 1 cycle at the computed latency, no error pulses.
- Parity error: 0x85 sent with parity 1 (expected 0) -> parity_error 1 cycle, DATA_VALID=0, P_DATA stays 0xF9.
- Framing error: 0x40 with stop=0 and line held low for 3 bit times -> framing_error 1 cycle. Then 0xF2 with parity 0 -> P_DATA=0xF2, DATA_VALID pulse.
- Glitch: rx_in low for 2 clocks -> busy_flag rises then falls by the START vote, no pulses, P_DATA unchanged.
- Back-to-back: 0xF9 then 0x85 (parity 0) with zero idle gap -> two DATA_VALID pulses exactly 11*PRESCALE clocks apart, P_DATA = 0xF9 then 0x85.
